// File: rtl/button_event_gen.sv
// Raw push-button front end: synchronizer, debounce, 1 s tick divider and a
// press / long-press / auto-repeat FSM producing registered one-cycle pulses.
module button_event_gen #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_PRESS_S    = 2,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic tick_1s,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int unsigned TickW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RepW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [TickW-1:0] TickMax = TickW'(CLK_HZ - 1);
    localparam logic [DebW-1:0]  DebMax  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0]  RepMax  = RepW'(REPEAT_CYCLES - 1);
    localparam logic [7:0]       SecMax  = 8'(LONG_PRESS_S - 1);

    typedef enum logic [1:0] {StIdle, StShort, StLong} state_e;

    logic [TickW-1:0] tick_cnt_q;
    logic             s1_q, s2_q;
    logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d;
    state_e           state_q, state_d;
    logic [7:0]       sec_cnt_q, sec_cnt_d;
    logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;

    assign tick_1s = (tick_cnt_q == TickMax);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick_1s) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TickW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    // Level only moves after s2 has disagreed with it for DEBOUNCE_CYCLES edges.
    always_comb begin
        deb_cnt_d = '0;
        level_d   = level_q;
        if (s2_q != level_q) begin
            if (deb_cnt_q == DebMax) begin
                level_d = s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DebW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
        end
    end

    // Release is tested first in SHORT/LONG so it wins over a coincident tick or repeat.
    always_comb begin
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        rep_cnt_d = rep_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (level_q) begin
                    state_d   = StShort;
                    press_d   = 1'b1;
                    sec_cnt_d = '0;
                end
            end
            StShort: begin
                if (!level_q) begin
                    state_d   = StIdle;
                    release_d = 1'b1;
                    sec_cnt_d = '0;
                    rep_cnt_d = '0;
                end else if (tick_1s) begin
                    sec_cnt_d = sec_cnt_q + 8'd1;
                    if (sec_cnt_q == SecMax) begin
                        state_d   = StLong;
                        long_d    = 1'b1;
                        rep_cnt_d = '0;
                    end
                end
            end
            StLong: begin
                if (!level_q) begin
                    state_d   = StIdle;
                    release_d = 1'b1;
                    sec_cnt_d = '0;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == RepMax) begin
                    rep_cnt_d = '0;
                    repeat_d  = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + RepW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            sec_cnt_q <= '0;
            rep_cnt_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_cnt_q <= sec_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule
